// File: rtl/imem_pkg.sv
// Shared definitions for the single-cycle CPU instruction memory.
// Holds the geometry constants, the instruction word type and the default
// program image loaded on reset. Words 0..15 are the CPU bring-up program;
// the remaining words are NOPs (all zero).
package imem_pkg;

    localparam int IMEM_DEPTH_WORDS = 64;
    localparam int IMEM_ADDR_W      = 32;
    localparam int IMEM_DATA_W      = 32;

    typedef logic [31:0] instr_t;

    localparam instr_t NOP_WORD = 32'h0000_0000;

    // Bring-up program (MIPS-style encoding):
    //   addi/add/sw/lw round trip, a branch on the loaded value,
    //   a few ALU ops, then a jump-to-self halt loop at word 15.
    localparam instr_t IMEM_INIT [0:63] = '{
        32'h2001_0001, 32'h2002_0002, 32'h0022_1820, 32'hAC03_0040,
        32'h8C04_0040, 32'h1064_0002, 32'h2005_0BAD, 32'h0800_000F,
        32'h2005_600D, 32'h0085_3022, 32'h00C0_3825, 32'h00E6_4024,
        32'h0107_482A, 32'hAC09_0044, 32'h2108_0001, 32'h0800_000F,
        32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
        32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
        32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
        32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
        32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
        32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0
    };

endpackage

// File: rtl/instruct_memory.sv
// Instruction memory: 64 x 32-bit words, byte addressed.
//   clk         - single clock, state changes on rising edge
//   rst         - synchronous active-high reset, reloads the default image
//   ImemRdAddr  - fetch byte address from the PC
//   Instruct    - instruction word at ImemRdAddr, combinational (no clock)
//   ImemAddrErr - fetch address misaligned or beyond the memory
//   ImemWrEn    - program-load write enable
//   ImemWrAddr  - program-load byte address (low two bits ignored)
//   ImemWrData  - program-load word
// Fetch is zero-latency so the single-cycle CPU decodes in the same cycle
// the PC is presented. Writes are not bypassed onto the read port.
module instruct_memory
    import imem_pkg::*;
#(
    parameter int ADDR_W      = IMEM_ADDR_W,
    parameter int DATA_W      = IMEM_DATA_W,
    parameter int DEPTH_WORDS = IMEM_DEPTH_WORDS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ImemRdAddr,
    output logic [DATA_W-1:0] Instruct,
    output logic              ImemAddrErr,
    input  logic              ImemWrEn,
    input  logic [ADDR_W-1:0] ImemWrAddr,
    input  logic [DATA_W-1:0] ImemWrData
);

    localparam int                IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_W-1:0] MEM_BYTES = ADDR_W'(4 * DEPTH_WORDS);

    logic [DATA_W-1:0] mem [0:DEPTH_WORDS-1];

    logic             rd_in_range;
    logic             wr_in_range;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;

    assign rd_in_range = (ImemRdAddr < MEM_BYTES);
    assign wr_in_range = (ImemWrAddr < MEM_BYTES);
    assign rd_idx      = ImemRdAddr[IDX_W+1:2];
    assign wr_idx      = ImemWrAddr[IDX_W+1:2];

    // Out-of-range fetches return a NOP rather than wrapping, so a runaway
    // PC cannot re-execute the program from word 0.
    assign Instruct    = rd_in_range ? mem[rd_idx] : DATA_W'(NOP_WORD);
    assign ImemAddrErr = (ImemRdAddr[1:0] != 2'b00) || !rd_in_range;

    // Reset reloads the whole image in a single edge and beats a
    // simultaneous write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] <= DATA_W'(IMEM_INIT[i % IMEM_DEPTH_WORDS]);
            end
        end else if (ImemWrEn && wr_in_range) begin
            mem[wr_idx] <= ImemWrData;
        end
    end

endmodule

// File: tb/tb_instruct_memory.sv
// Directed bench for instruct_memory. Expected words come from a
// bench-local copy of the bring-up program and a shadow memory updated by
// the bench as it issues writes and resets.
module tb_instruct_memory;

    logic        clk;
    logic        rst;
    logic [31:0] ImemRdAddr;
    logic [31:0] Instruct;
    logic        ImemAddrErr;
    logic        ImemWrEn;
    logic [31:0] ImemWrAddr;
    logic [31:0] ImemWrData;

    int vectors;
    int miscompares;

    logic [31:0] prog [0:15];
    logic [31:0] shadow [0:63];

    instruct_memory dut (
        .clk        (clk),
        .rst        (rst),
        .ImemRdAddr (ImemRdAddr),
        .Instruct   (Instruct),
        .ImemAddrErr(ImemAddrErr),
        .ImemWrEn   (ImemWrEn),
        .ImemWrAddr (ImemWrAddr),
        .ImemWrData (ImemWrData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_word(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic check_err(input string tag, input logic obs, input logic expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    task automatic shadow_reset();
        for (int i = 0; i < 64; i++) shadow[i] = (i < 16) ? prog[i] : 32'h0;
    endtask

    // Read every word and compare against the shadow memory.
    task automatic sweep(input string tag);
        for (int i = 0; i < 64; i++) begin
            ImemRdAddr = 32'(i * 4);
            #1;
            check_word(tag, Instruct, shadow[i]);
            check_err(tag, ImemAddrErr, 1'b0);
            #4;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        prog[0]  = 32'h2001_0001; prog[1]  = 32'h2002_0002;
        prog[2]  = 32'h0022_1820; prog[3]  = 32'hAC03_0040;
        prog[4]  = 32'h8C04_0040; prog[5]  = 32'h1064_0002;
        prog[6]  = 32'h2005_0BAD; prog[7]  = 32'h0800_000F;
        prog[8]  = 32'h2005_600D; prog[9]  = 32'h0085_3022;
        prog[10] = 32'h00C0_3825; prog[11] = 32'h00E6_4024;
        prog[12] = 32'h0107_482A; prog[13] = 32'hAC09_0044;
        prog[14] = 32'h2108_0001; prog[15] = 32'h0800_000F;

        rst        = 1'b1;
        ImemRdAddr = 32'h0;
        ImemWrEn   = 1'b0;
        ImemWrAddr = 32'h0;
        ImemWrData = 32'h0;

        // 1: reset image, full sweep (program words and zero tail)
        tick();
        rst = 1'b0;
        shadow_reset();
        sweep("reset_image");

        // 2: aligned write, then aligned and misaligned reads of it
        ImemWrAddr = 32'h04; ImemWrData = 32'h2001_0005; ImemWrEn = 1'b1;
        tick();
        ImemWrEn = 1'b0;
        shadow[1] = 32'h2001_0005;
        ImemRdAddr = 32'h04; #1;
        check_word("wr_rd_04", Instruct, 32'h2001_0005);
        check_err("wr_err_04", ImemAddrErr, 1'b0);
        ImemRdAddr = 32'h05; #1;
        check_word("rd_05_word", Instruct, 32'h2001_0005);
        check_err("rd_05_err", ImemAddrErr, 1'b1);
        ImemRdAddr = 32'h07; #1;
        check_word("rd_07_word", Instruct, 32'h2001_0005);
        check_err("rd_07_err", ImemAddrErr, 1'b1);

        // misaligned write address lands on the enclosing word
        ImemWrAddr = 32'h0E; ImemWrData = 32'hA5A5_0003; ImemWrEn = 1'b1;
        tick();
        ImemWrEn = 1'b0;
        shadow[3] = 32'hA5A5_0003;
        ImemRdAddr = 32'h0C; #1;
        check_word("wr_mis_0e", Instruct, 32'hA5A5_0003);

        // 3: out-of-range reads and boundary
        ImemRdAddr = 32'hFC; #1;
        check_word("rd_last_word", Instruct, 32'h0);
        check_err("rd_last_err", ImemAddrErr, 1'b0);
        ImemRdAddr = 32'h100; #1;
        check_word("rd_100_word", Instruct, 32'h0);
        check_err("rd_100_err", ImemAddrErr, 1'b1);
        ImemRdAddr = 32'hFFFF_FFFC; #1;
        check_word("rd_top_word", Instruct, 32'h0);
        check_err("rd_top_err", ImemAddrErr, 1'b1);
        ImemRdAddr = 32'h104; #1;
        check_word("rd_104_nowrap", Instruct, 32'h0);

        // out-of-range writes are dropped (0x100 and 0x104 would alias words 0,1)
        ImemWrAddr = 32'h100; ImemWrData = 32'hCAFE_F00D; ImemWrEn = 1'b1;
        tick();
        ImemWrAddr = 32'h104;
        tick();
        ImemWrEn = 1'b0;
        sweep("oor_write");

        // 4: reset wins over a simultaneous write
        rst = 1'b1;
        ImemWrAddr = 32'h04; ImemWrData = 32'hDEAD_BEEF; ImemWrEn = 1'b1;
        tick();
        rst = 1'b0; ImemWrEn = 1'b0;
        shadow_reset();
        ImemRdAddr = 32'h04; #1;
        check_word("rst_wins_04", Instruct, 32'h2002_0002);
        ImemRdAddr = 32'h0C; #1;
        check_word("rst_reload_0c", Instruct, 32'hAC03_0040);

        // 5: read-during-write on the same word, no bypass
        ImemRdAddr = 32'h08;
        ImemWrAddr = 32'h08; ImemWrData = 32'h1234_5678; ImemWrEn = 1'b1;
        #1;
        check_word("rdw_before", Instruct, 32'h0022_1820);
        tick();
        ImemWrEn = 1'b0;
        shadow[2] = 32'h1234_5678;
        check_word("rdw_after", Instruct, 32'h1234_5678);

        sweep("final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
